unified_mem_arbiter: RTL and testbench

- Shares one memory port between instruction fetch and LSU data requests, so the core can run on a single unified memory.
- Sequences each access with a request/acknowledge handshake against variable-latency memory.
- Grants fairly when both sides are pending.
- Drives a stall to the core while any access is outstanding, and aborts hung accesses on timeout.

---
 rtl/unified_mem_arbiter_if.sv | 24 ++
 rtl/unified_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the unified memory arbiter.
// master: the arbiter (drives m_req/m_we/m_addr/m_wdata, receives m_ack/m_rdata).
// slave : the memory (receives the request, returns m_ack with m_rdata).
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one memory port between instruction fetch
// and LSU data accesses, with fair alternation under contention, a
// request/acknowledge handshake to variable-latency memory, a core stall and
// a timeout that aborts hung accesses.
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   if_req/if_addr             fetch request (level) and address
//   if_rdata/if_valid          fetched word and one-cycle completion pulse
//   d_read_req/d_write_req     load request / store byte enables (levels)
//   d_addr/d_wdata             data address and store data
//   d_rdata/d_valid            load data and one-cycle completion pulse
//   stall                      core hold while any request is outstanding
//   bus_error                  pulses with the valid of an aborted access
//   mem                        memory bus (master side)
module unified_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read_req,
  input  logic [3:0]        d_write_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall,
  output logic              bus_error,
  unified_mem_arbiter_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              last_grant_r, last_grant_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              req_r, req_s;
  logic [3:0]        we_r, we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
  logic              if_valid_r, if_valid_s;
  logic              d_valid_r, d_valid_s;
  logic              bus_error_r, bus_error_s;
  logic              d_pend;

  assign d_pend = d_read_req | (|d_write_req);

  // Stall is combinational so the core freezes in the same cycle it asks.
  assign stall = (if_req & ~if_valid_r) | (d_pend & ~d_valid_r);

  assign mem.m_req   = req_r;
  assign mem.m_we    = we_r;
  assign mem.m_addr  = addr_r;
  assign mem.m_wdata = wdata_r;
  assign if_rdata    = if_rdata_r;
  assign if_valid    = if_valid_r;
  assign d_rdata     = d_rdata_r;
  assign d_valid     = d_valid_r;
  assign bus_error   = bus_error_r;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, grant decision, timeout and completion values.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    req_s        = req_r;
    we_s         = we_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    if_rdata_s   = if_rdata_r;
    d_rdata_s    = d_rdata_r;
    if_valid_s   = 1'b0;
    d_valid_s    = 1'b0;
    bus_error_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Fetch wins when alone or when data was granted last.
        if (if_req && (!d_pend || (last_grant_r == GRANT_D))) begin
          state_s      = BUSY_F;
          last_grant_s = GRANT_F;
          cnt_s        = '0;
          req_s        = 1'b1;
          we_s         = 4'b0000;
          addr_s       = if_addr;
          wdata_s      = '0;
        end else if (d_pend) begin
          // A store takes precedence over a simultaneous load.
          state_s      = BUSY_D;
          last_grant_s = GRANT_D;
          cnt_s        = '0;
          req_s        = 1'b1;
          we_s         = d_write_req;
          addr_s       = d_addr;
          wdata_s      = d_wdata;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_F, BUSY_D: begin
        if (mem.m_ack) begin
          req_s   = 1'b0;
          state_s = IDLE;
          if (state_r == BUSY_F) begin
            if_valid_s = 1'b1;
            if_rdata_s = mem.m_rdata;
          end else begin
            d_valid_s = 1'b1;
            d_rdata_s = (|we_r) ? '0 : mem.m_rdata;
          end
        end else if (cnt_r == CNT_LAST) begin
          // This cycle is the last allowed unacknowledged one: abort.
          req_s       = 1'b0;
          state_s     = ERR;
          bus_error_s = 1'b1;
          if (state_r == BUSY_F) begin
            if_valid_s = 1'b1;
            if_rdata_s = '0;
          end else begin
            d_valid_s = 1'b1;
            d_rdata_s = '0;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ERR: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered memory-bus and core-side outputs plus arbitration history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= GRANT_D;
      cnt_r        <= '0;
      req_r        <= 1'b0;
      we_r         <= 4'b0000;
      addr_r       <= '0;
      wdata_r      <= '0;
      if_rdata_r   <= '0;
      d_rdata_r    <= '0;
      if_valid_r   <= 1'b0;
      d_valid_r    <= 1'b0;
      bus_error_r  <= 1'b0;
    end else begin
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      req_r        <= req_s;
      we_r         <= we_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      if_rdata_r   <= if_rdata_s;
      d_rdata_r    <= d_rdata_s;
      if_valid_r   <= if_valid_s;
      d_valid_r    <= d_valid_s;
      bus_error_r  <= bus_error_s;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: stimulus pushes expected memory
// accesses and completions into queues; monitors pop and compare them.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read_req;
  logic [3:0]  d_write_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        bus_error;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .stall(stall), .bus_error(bus_error), .mem(bus)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];
  int    total = 0;
  int    bad = 0;
  int    mem_wait = 0;
  bit    mem_noack = 0;
  int    mcnt = 0;
  bit    in_burst = 0;
  bit    have_cur = 0;
  int    blen = 0;
  int    n_bursts = 0;
  acc_t  cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks after mem_wait wait cycles unless mem_noack is set.
  always @(negedge clk) begin
    if (bus.m_req && !reset) begin
      if (!mem_noack && mcnt == mem_wait) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = mem_data(bus.m_addr);
      end else begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = 32'hFFFF_FFFF;
      end
      mcnt++;
    end else begin
      bus.m_ack   = 1'b0;
      bus.m_rdata = 32'hFFFF_FFFF;
      mcnt = 0;
    end
  end

  // Bus monitor: checks each access against the expected one, its
  // stability while m_req is high and its length in cycles.
  always @(negedge clk) begin
    if (reset) begin
      in_burst = 0;
      have_cur = 0;
    end else if (bus.m_req) begin
      if (!in_burst) begin
        in_burst = 1;
        blen = 1;
        n_bursts++;
        if (acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_access: addr %0h we %0h, none expected", bus.m_addr, bus.m_we);
        end else begin
          cur = acc_q.pop_front();
          have_cur = 1;
          chk("acc_we", bus.m_we, cur.we);
          chk("acc_addr", bus.m_addr, cur.addr);
          if (cur.we != 4'b0000) chk("acc_wdata", bus.m_wdata, cur.wdata);
        end
      end else begin
        blen++;
        if (have_cur) begin
          chk("hold_we", bus.m_we, cur.we);
          chk("hold_addr", bus.m_addr, cur.addr);
          if (cur.we != 4'b0000) chk("hold_wdata", bus.m_wdata, cur.wdata);
        end
      end
    end else if (in_burst) begin
      in_burst = 0;
      if (have_cur) chk("burst_len", blen, cur.len);
      have_cur = 0;
    end
  end

  task automatic check_resp(input logic is_d, input logic [31:0] rdata);
    resp_t r;
    if (resp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_valid: side %0d rdata %0h, none expected", is_d, rdata);
    end else begin
      r = resp_q.pop_front();
      chk("resp_side", is_d, r.is_d);
      chk("resp_rdata", rdata, r.rdata);
      chk("resp_bus_error", bus_error, r.err);
    end
  endtask

  // Response monitor: every valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (if_valid) check_resp(1'b0, if_rdata);
      if (d_valid) check_resp(1'b1, d_rdata);
    end
  end

  task automatic push_acc(input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int len);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wdata; a.len = len;
    acc_q.push_back(a);
  endtask

  task automatic push_resp(input logic is_d, input logic [31:0] rdata, input logic err);
    resp_t r;
    r.is_d = is_d; r.rdata = rdata; r.err = err;
    resp_q.push_back(r);
  endtask

  // One request on one side, held until its valid; returns latency in cycles.
  task automatic do_req(input bit side_d, input logic rd, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    bit got = 0;
    @(negedge clk);
    if (!side_d) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_read_req = rd; d_write_req = we; d_addr = addr; d_wdata = wdata;
    end
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (side_d ? d_valid : if_valid) begin
        chk("stall_on_valid", stall, 1'b0);
        got = 1;
        break;
      end else begin
        chk("stall_busy", stall, 1'b1);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL req_timeout: no valid for addr %0h within 100 cycles", addr);
    end
    if_req = 1'b0; d_read_req = 1'b0; d_write_req = 4'b0000;
  endtask

  // Fetch and load held together for the given number of rounds.
  task automatic contend(input int rounds);
    int nd = 0;
    bit got = 0;
    for (int r = 0; r < rounds; r++) begin
      push_acc(4'b0000, 32'h300, 32'h0, 1);
      push_resp(1'b0, mem_data(32'h300), 1'b0);
      push_acc(4'b0000, 32'h400, 32'h0, 1);
      push_resp(1'b1, mem_data(32'h400), 1'b0);
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    d_read_req = 1'b1; d_addr = 32'h400;
    for (int i = 0; i < 40 * rounds + 20; i++) begin
      @(negedge clk);
      if (d_valid) begin
        nd++;
        if (nd == rounds) begin
          got = 1;
          break;
        end
      end
    end
    if_req = 1'b0; d_read_req = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL contend_timeout: %0d of %0d data completions", nd, rounds);
    end
  endtask

  initial begin
    int lat;
    int n0;
    bit seen;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_read_req = 1'b0; d_write_req = 4'b0000; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", bus.m_req, 1'b0);
    chk("rst_m_we", bus.m_we, 4'b0000);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_bus_error", bus_error, 1'b0);
    chk("rst_stall", stall, 1'b0);
    reset = 1'b0;

    // Contention right after reset: fetch first, then alternating.
    contend(10);

    // Single fetch with immediate ack.
    mem_wait = 0;
    push_acc(4'b0000, 32'h100, 32'h0, 1);
    push_resp(1'b0, 32'h0050_0093, 1'b0);
    do_req(1'b0, 1'b0, 4'b0000, 32'h100, 32'h0, lat);
    chk("fetch_latency", lat, 2);

    // Store with three wait cycles.
    mem_wait = 3;
    push_acc(4'b0011, 32'h2002, 32'hABCD, 4);
    push_resp(1'b1, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 4'b0011, 32'h2002, 32'hABCD, lat);
    chk("store_latency", lat, 5);
    mem_wait = 0;
    @(negedge clk);
    chk("if_rdata_hold", if_rdata, 32'h0050_0093);
    chk("d_rdata_store", d_rdata, 32'h0);

    // Load and store together: a single store access.
    n0 = n_bursts;
    push_acc(4'b1111, 32'h600, 32'h1234_5678, 1);
    push_resp(1'b1, 32'h0, 1'b0);
    do_req(1'b1, 1'b1, 4'b1111, 32'h600, 32'h1234_5678, lat);
    chk("ldst_latency", lat, 2);
    repeat (3) @(negedge clk);
    chk("ldst_one_access", n_bursts - n0, 1);

    // Plain load so the timeout below must clear a nonzero d_rdata.
    push_acc(4'b0000, 32'h700, 32'h0, 1);
    push_resp(1'b1, mem_data(32'h700), 1'b0);
    do_req(1'b1, 1'b1, 4'b0000, 32'h700, 32'h0, lat);

    // Timeout: memory never acks.
    mem_noack = 1;
    push_acc(4'b0000, 32'h500, 32'h0, 4);
    push_resp(1'b1, 32'h0, 1'b1);
    do_req(1'b1, 1'b1, 4'b0000, 32'h500, 32'h0, lat);
    chk("timeout_latency", lat, 5);
    mem_noack = 0;
    push_acc(4'b0000, 32'h504, 32'h0, 1);
    push_resp(1'b1, mem_data(32'h504), 1'b0);
    do_req(1'b1, 1'b1, 4'b0000, 32'h504, 32'h0, lat);
    chk("after_timeout_latency", lat, 2);

    // Reset in the middle of a data access.
    mem_noack = 1;
    push_acc(4'b0000, 32'h800, 32'h0, 1);
    @(negedge clk);
    d_read_req = 1'b1; d_addr = 32'h800;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_req) begin
        seen = 1;
        break;
      end
    end
    chk("midrst_m_req_seen", seen, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_m_req", bus.m_req, 1'b0);
    chk("midrst_d_valid", d_valid, 1'b0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    chk("midrst_if_rdata", if_rdata, 32'h0);
    d_read_req = 1'b0;
    mem_noack = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    contend(1);

    repeat (5) @(negedge clk);
    chk("resp_q_empty", resp_q.size(), 0);
    chk("acc_q_empty", acc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
